// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debouncer and related input conditioning.
package debounce_pkg;

    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} db_state_t;

    // Width of the stability counter; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for asynchronous single-bit inputs.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift chain clearing to 0 on reset; no logic between stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw push-button, producing a clean level and
// single-cycle press/release pulses aligned with the first cycle of each new level.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic button_clean,
    output logic press,
    output logic release_pulse
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             btn_s;
    db_state_t        state_r;
    db_state_t        state_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             press_s;
    logic             release_s;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (button),
        .q    (btn_s)
    );

    // Next-state and pulse decode; any disagreeing sample restarts from zero.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        case (state_r)
            S_LOW: begin
                if (btn_s) begin
                    state_s = S_RISE;
                    count_s = CNT_ONE;
                end else begin
                    state_s = S_LOW;
                end
            end
            S_RISE: begin
                if (!btn_s) begin
                    state_s = S_LOW;
                    count_s = '0;
                end else if (count_r == CNT_LAST) begin
                    state_s = S_HIGH;
                    count_s = '0;
                    press_s = 1'b1;
                end else begin
                    count_s = count_r + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!btn_s) begin
                    state_s = S_FALL;
                    count_s = CNT_ONE;
                end else begin
                    state_s = S_HIGH;
                end
            end
            S_FALL: begin
                if (btn_s) begin
                    state_s = S_HIGH;
                    count_s = '0;
                end else if (count_r == CNT_LAST) begin
                    state_s   = S_LOW;
                    count_s   = '0;
                    release_s = 1'b1;
                end else begin
                    count_s = count_r + CNT_ONE;
                end
            end
            default: begin
                state_s = S_LOW;
                count_s = '0;
            end
        endcase
    end

    // State, counter and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_LOW;
            count_r       <= '0;
            button_clean  <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            button_clean  <= (state_s == S_HIGH) || (state_s == S_FALL);
            press         <= press_s;
            release_pulse <= release_s;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a small LED toggle model driven by press.
module tb_button_debouncer;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic button = 1'b0;
    logic button_clean;
    logic press;
    logic release_pulse;
    logic led;

    int checks = 0;
    int passed = 0;

    always #10 clk = ~clk;

    button_debouncer #(
        .STABLE_CYCLES(4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button       (button),
        .button_clean (button_clean),
        .press        (press),
        .release_pulse(release_pulse)
    );

    // LED toggle controller stand-in: flips on each press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led <= 1'b0;
        end else if (press) begin
            led <= ~led;
        end else begin
            led <= led;
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // n cycles with no pulses and a fixed clean level.
    task automatic hold(input string tag, input int n, input logic clean_exp);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check({tag, " press"}, press, 1'b0);
            check({tag, " release"}, release_pulse, 1'b0);
            check({tag, " clean"}, button_clean, clean_exp);
        end
    endtask

    // n cycles after an input change; pulse_at = edge of the expected level change (0 = none).
    task automatic watch(input string tag, input int n, input int pulse_at, input logic clean_before,
                         input logic chk_led, input logic led_before);
        logic exp_clean;
        logic exp_led;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            exp_clean = ((pulse_at != 0) && (k >= pulse_at)) ? ~clean_before : clean_before;
            exp_led   = ((pulse_at != 0) && (k > pulse_at) && !clean_before) ? ~led_before : led_before;
            check({tag, " clean"}, button_clean, exp_clean);
            check({tag, " press"}, press, (k == pulse_at) && !clean_before);
            check({tag, " release"}, release_pulse, (k == pulse_at) && clean_before);
            if (chk_led) begin
                check({tag, " led"}, led, exp_led);
            end
        end
    endtask

    initial begin
        logic [3:0] pat;

        // 1: reset held with button high, then full latency after deassert
        reset  = 1'b0;
        button = 1'b1;
        hold("s1 in reset", 5, 1'b0);
        reset = 1'b1;
        watch("s1 after reset", 10, 6, 1'b0, 1'b0, 1'b0);

        // 2: clean release, press, release
        button = 1'b0;
        watch("s2 to low", 12, 6, 1'b1, 1'b0, 1'b0);
        button = 1'b1;
        watch("s2 press", 20, 6, 1'b0, 1'b0, 1'b0);
        button = 1'b0;
        watch("s2 release", 20, 6, 1'b1, 1'b0, 1'b0);

        // 3: bounce 1,1,1,0 then steady 1
        pat = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            button = pat[i];
            hold("s3 bounce", 1, 1'b0);
        end
        button = 1'b1;
        watch("s3 settle", 16, 6, 1'b0, 1'b0, 1'b0);

        // 4: two-cycle low glitch while high
        button = 1'b0;
        hold("s4 glitch", 2, 1'b1);
        button = 1'b1;
        watch("s4 after glitch", 12, 0, 1'b1, 1'b0, 1'b0);

        // 5: reset asserted mid-count
        button = 1'b0;
        watch("s5 to low", 10, 6, 1'b1, 1'b0, 1'b0);
        button = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("s5 async clean", button_clean, 1'b0);
        check("s5 async press", press, 1'b0);
        hold("s5 in reset", 2, 1'b0);
        reset = 1'b1;
        watch("s5 after reset", 10, 6, 1'b0, 1'b0, 1'b0);

        // 6: asynchronous clear from high, then press/release/press into the LED model
        reset  = 1'b0;
        button = 1'b0;
        #1;
        check("s6 async clean", button_clean, 1'b0);
        check("s6 async led", led, 1'b0);
        hold("s6 in reset", 2, 1'b0);
        reset = 1'b1;
        hold("s6 idle", 3, 1'b0);
        button = 1'b1;
        watch("s6 press1", 12, 6, 1'b0, 1'b1, 1'b0);
        button = 1'b0;
        watch("s6 release", 12, 6, 1'b1, 1'b1, 1'b1);
        button = 1'b1;
        watch("s6 press2", 12, 6, 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
